// File: rtl/lsb_priority_arbiter_if.sv
// Request/grant bundle between the requesters and the arbiter.
interface lsb_priority_arbiter_if #(
  parameter int WIDTH = 4
);
  localparam int IW = $clog2(WIDTH);

  logic             mode;
  logic [WIDTH-1:0] req;
  logic [WIDTH-1:0] gnt;
  logic [IW-1:0]    gnt_idx;
  logic             busy;

  modport master (output mode, output req, input gnt, input gnt_idx, input busy);
  modport slave  (input mode, input req, output gnt, output gnt_idx, output busy);
endinterface

// File: rtl/lsb_priority_arbiter.sv
// Single-owner arbiter with fixed LSB-first or round-robin selection and an
// optional cap on consecutive grant cycles.
//
// state | meaning
// IDLE  | no owner; arbitrate on the next edge if any request is pending
// GRANT | one owner holds gnt until it drops its request or hits MAX_HOLD
module lsb_priority_arbiter #(
  parameter int WIDTH    = 4,
  parameter int MAX_HOLD = 8
) (
  input logic clk,
  input logic rst,
  lsb_priority_arbiter_if.slave bus
);
  localparam int IW = $clog2(WIDTH);
  localparam int HW = (MAX_HOLD < 2) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] HOLD_LIM = HW'(MAX_HOLD);
  localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] gnt_q, gnt_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [IW-1:0]    ptr_q, ptr_d;
  logic [HW-1:0]    hold_q, hold_d;

  logic [IW-1:0]    idx_hi, idx_lo, win_idx;
  logic             hit_hi;
  logic             owner_req;
  logic             hold_max;

  // Winner search: lowest set bit at/above ptr, and lowest set bit overall.
  always_comb begin
    hit_hi = 1'b0;
    idx_hi = '0;
    idx_lo = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (bus.req[i]) begin
        idx_lo = IW'(i);
        if (IW'(i) >= ptr_q) begin
          hit_hi = 1'b1;
          idx_hi = IW'(i);
        end
      end
    end
    win_idx = (bus.mode && hit_hi) ? idx_hi : idx_lo;
  end

  assign owner_req = bus.req[idx_q];
  assign hold_max  = (MAX_HOLD != 0) && (hold_q == HOLD_LIM);

  // Next-state, grant and pointer logic.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    case (state_q)
      IDLE: begin
        if (|bus.req) begin
          state_d = GRANT;
          gnt_d   = {{(WIDTH-1){1'b0}}, 1'b1} << win_idx;
          idx_d   = win_idx;
          hold_d  = HW'(1);
        end
      end
      GRANT: begin
        if (!owner_req || hold_max) begin
          // Release always passes through IDLE, giving one all-zero cycle.
          state_d = IDLE;
          gnt_d   = '0;
          idx_d   = '0;
          ptr_d   = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        idx_d   = '0;
      end
    endcase
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      idx_q   <= '0;
      ptr_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.gnt_idx = idx_q;
  assign bus.busy    = |gnt_q;
endmodule

// File: tb/tb_lsb_priority_arbiter.sv
// Directed and randomized checks for lsb_priority_arbiter (WIDTH=4, MAX_HOLD=3).
module tb_lsb_priority_arbiter;
  localparam int WIDTH    = 4;
  localparam int MAX_HOLD = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  lsb_priority_arbiter_if #(.WIDTH(WIDTH)) bus ();

  lsb_priority_arbiter #(.WIDTH(WIDTH), .MAX_HOLD(MAX_HOLD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [3:0] exp_q[$];

  function automatic logic [1:0] enc(input logic [3:0] g);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 0; i < 4; i++) if (g[i]) r = 2'(i);
    return r;
  endfunction

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Drive one cycle of stimulus, push the grant expected after the edge,
  // then pop it and compare gnt, gnt_idx and busy.
  task automatic step(input string tag, input logic r, input logic m,
                      input logic [3:0] rq, input logic [3:0] exp);
    logic [3:0] e;
    rst      = r;
    bus.mode = m;
    bus.req  = rq;
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check({tag, ".gnt"},  bus.gnt, e);
    check({tag, ".idx"},  {2'b00, bus.gnt_idx}, {2'b00, enc(e)});
    check({tag, ".busy"}, {3'b000, bus.busy}, {3'b000, |e});
  endtask

  logic [3:0] prev_gnt;
  logic [3:0] rq;
  logic       r_rnd;
  logic       m_rnd;

  initial begin
    bus.mode = 1'b0;
    bus.req  = '0;

    // Reset, including a request presented during reset
    step("rst0", 1, 0, 4'b0000, 4'b0000);
    step("rst1", 1, 0, 4'b0110, 4'b0000);
    step("idle_noreq", 0, 0, 4'b0000, 4'b0000);

    // Fixed priority
    step("fix.g1",   0, 0, 4'b0110, 4'b0010);
    step("fix.hold", 0, 0, 4'b0110, 4'b0010);
    step("fix.drop", 0, 0, 4'b0100, 4'b0000);
    step("fix.next", 0, 0, 4'b0100, 4'b0100);
    step("fix.rel",  0, 0, 4'b0000, 4'b0000);
    step("fix.idle", 0, 1, 4'b0000, 4'b0000);

    // ptr = 3 after releasing index 2: round-robin picks 3 first
    step("rr.ptr3", 0, 1, 4'b1001, 4'b1000);
    step("rr.wrap", 0, 1, 4'b0000, 4'b0000);

    // Round-robin with hold-limit releases, ptr starts at 0
    step("rr.a1",   0, 1, 4'b1001, 4'b0001);
    step("rr.a2",   0, 1, 4'b1001, 4'b0001);
    step("rr.a3",   0, 1, 4'b1001, 4'b0001);
    step("rr.gap1", 0, 1, 4'b1001, 4'b0000);
    step("rr.b1",   0, 1, 4'b1001, 4'b1000);
    step("rr.b2",   0, 1, 4'b1001, 4'b1000);
    step("rr.b3",   0, 1, 4'b1001, 4'b1000);
    step("rr.gap2", 0, 1, 4'b1001, 4'b0000);
    step("rr.c1",   0, 1, 4'b1001, 4'b0001);
    step("rr.crel", 0, 1, 4'b0000, 4'b0000);

    // Hold limit with a single constant requester
    step("hl.1",     0, 0, 4'b0001, 4'b0001);
    step("hl.2",     0, 0, 4'b0001, 4'b0001);
    step("hl.3",     0, 0, 4'b0001, 4'b0001);
    step("hl.gap",   0, 0, 4'b0001, 4'b0000);
    step("hl.again", 0, 0, 4'b0001, 4'b0001);
    step("hl.rel",   0, 0, 4'b0000, 4'b0000);

    // Mode change mid-grant (ptr = 1 here)
    step("mc.g",    0, 1, 4'b0100, 4'b0100);
    step("mc.h2",   0, 0, 4'b1110, 4'b0100);
    step("mc.h3",   0, 0, 4'b1110, 4'b0100);
    step("mc.lim",  0, 0, 4'b1110, 4'b0000);
    step("mc.next", 0, 0, 4'b1110, 4'b0010);

    // Reset during an active grant clears ptr
    step("rs.drop",  0, 0, 4'b1000, 4'b0000);
    step("rs.g",     0, 0, 4'b1000, 4'b1000);
    step("rs.pulse", 1, 0, 4'b1000, 4'b0000);
    step("rs.rr",    0, 1, 4'b1010, 4'b0010);
    step("rs.rel",   0, 1, 4'b0000, 4'b0000);

    // Randomized invariants
    prev_gnt = bus.gnt;
    for (int k = 0; k < 400; k++) begin
      r_rnd    = ($urandom_range(0, 24) == 0);
      m_rnd    = 1'($urandom_range(0, 1));
      rq       = 4'($urandom_range(0, 15));
      rst      = r_rnd;
      bus.mode = m_rnd;
      bus.req  = rq;
      @(posedge clk);
      #1;
      check("rnd.onehot", {3'b000, $onehot0(bus.gnt)}, 4'b0001);
      check("rnd.idx",    {2'b00, bus.gnt_idx}, {2'b00, enc(bus.gnt)});
      check("rnd.busy",   {3'b000, bus.busy}, {3'b000, |bus.gnt});
      if (r_rnd)
        check("rnd.rst", bus.gnt, 4'b0000);
      else if (prev_gnt == 4'b0000 && bus.gnt != 4'b0000)
        check("rnd.granted_req", bus.gnt & rq, bus.gnt);
      if (prev_gnt != 4'b0000 && bus.gnt != 4'b0000)
        check("rnd.no_switch", bus.gnt, prev_gnt);
      prev_gnt = bus.gnt;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
